ftdi_rx_deframer: RTL and testbench
===================================

// Module: ftdi_rx_deframer
// PURPOSE
//  Packet deframer on the user rx side of ftdi_245fifo (rx_valid/rx_ready/rx_data, 16-bit words).
//  Hunts for a sync word, reads a length word, forwards the payload as a valid/ready stream with out_last.
//  Drops malformed packets and resynchronises. Feeds the downstream command/data consumers; single clock = rx_clk.
// PARAMETERS
//  SYNC_WORD  16'hA55A  header word 0 marking packet start
//  MAX_LEN    1024      max payload words accepted (1..65536); longer packets are rejected
// PORTS
//  clk         in   1   clock, same domain as ftdi_245fifo rx_clk
//  rstn_async  in   1   asynchronous active-low reset
//  in_valid    in   1   word valid from ftdi_245fifo rx_valid
//  in_ready    out  1   to ftdi_245fifo rx_ready
//  in_data     in   16  from ftdi_245fifo rx_data
//  out_valid   out  1   payload word valid
//  out_ready   in   1   downstream ready
//  out_data    out  16  payload word
//  out_last    out  1   high with final payload word of a packet
//  pkt_done    out  1   1-cycle pulse: packet fully accepted (after last word, or after checksum word if enabled)
//  len_err     out  1   1-cycle pulse: length word > MAX_LEN-1, packet dropped
//  csum_err    out  1   1-cycle pulse: checksum mismatch (tied 0 without FTDI_DEFRAMER_CSUM_EN)
//  pkt_cnt     out  16  count of pkt_done pulses, wraps 16'hFFFF -> 0
// BEHAVIOUR
//  - Reset: state=HUNT, in_ready=1, out_valid=0, out_last=0, pulses=0, pkt_cnt=0, word counter=0, sum=0.
//  - Transfer on valid&ready, both sides. No word ever duplicated or lost inside a PAYLOAD phase.
//  - HUNT: in_ready=1; words != SYNC_WORD discarded; SYNC_WORD -> LEN.
//  - LEN: in_ready=1; word N = payload length-1. N > MAX_LEN-1 -> len_err pulse next cycle, -> HUNT.
//    Else latch remaining=N, sum=0, -> PAYLOAD. A SYNC_WORD in LEN is treated as a length, not resync.
//  - PAYLOAD: combinational pass-through, zero latency: out_valid=in_valid, in_ready=out_ready,
//    out_data=in_data, out_last=(remaining==0). On transfer: remaining-=1, sum+=in_data (mod 2^16).
//    Transfer with remaining==0 -> CSUM if macro defined, else pulse pkt_done and -> HUNT.
//  - Outside PAYLOAD out_valid=0 and out_data/out_last are don't-care (drive 0).
//  - pkt_done/len_err/csum_err are registered, high exactly one cycle after the causing transfer.
//  - pkt_cnt increments in the same cycle pkt_done is high.
//  - Back-to-back: a SYNC_WORD directly following the last (or checksum) word is accepted with no idle cycle.
//  - Length 0 (1-word payload): single word carries out_last=1.
//  - Async reset mid-packet: returns to HUNT immediately; partial packet is abandoned, no pulses.
//  - out_ready low in PAYLOAD stalls input (in_ready=0); state and counters hold.
// CONFIGURATION
//  FTDI_DEFRAMER_CSUM_EN defined: adds state CSUM after PAYLOAD; in_ready=1; next word compared to
//    sum of payload words mod 2^16. Match -> pkt_done; mismatch -> csum_err and pkt_done both pulse,
//    pkt_cnt increments. Then -> HUNT. Checksum word never appears on out_*.
//  Not defined: no CSUM state, no sum register, csum_err constant 0, packet ends at out_last.
// TESTING
//  1. Reset, out_ready=1; send A55A,0002,0011,0022,0033 -> out 0011,0022,0033, out_last on 0033, pkt_done 1 pulse, pkt_cnt=1.
//  2. Garbage 1234,A5A5 then A55A,0000,BEEF -> garbage dropped, single word BEEF with out_last=1, pkt_cnt=1.
//  3. MAX_LEN=1024: A55A,0400,0001 -> len_err pulse, nothing on out_*, 0001 discarded in HUNT, pkt_cnt=0.
//  4. out_ready toggled randomly over 64-word packet -> in_ready follows out_ready, all 64 words in order, one out_last.
//  5. CSUM_EN: A55A,0001,0100,0200,0300 -> pkt_done, csum_err=0; repeat with 0301 -> csum_err and pkt_done pulse, pkt_cnt=2.
//  6. Reset asserted after 2 payload words of 5, then A55A,0000,0007 -> out 0007 with out_last, pkt_cnt=1.

Source files
------------

// File: rtl/ftdi_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module  : ftdi_rx_deframer
// Brief   : Sync/length packet deframer on the ftdi_245fifo rx stream; payload
//           is forwarded zero-latency. Optional checksum: FTDI_DEFRAMER_CSUM_EN.
// Revision: 1.0  initial release
// ============================================================================
module ftdi_rx_deframer #(
   parameter logic [15:0] SYNC_WORD = 16'hA55A,
   parameter int unsigned MAX_LEN   = 1024
) (
   input  logic        clk,
   input  logic        rstn_async,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        out_last,
   output logic        pkt_done,
   output logic        len_err,
   output logic        csum_err,
   output logic [15:0] pkt_cnt
);

   localparam logic [16:0] c_max_n = 17'(MAX_LEN - 1);

   typedef enum logic [1:0] {
      S_HUNT    = 2'd0,
      S_LEN     = 2'd1,
      S_PAYLOAD = 2'd2,
      S_CSUM    = 2'd3
   } state_t;

   state_t      r_state;
   logic [15:0] r_remaining;
   logic [15:0] r_pkt_cnt;
   logic        r_pkt_done;
   logic        r_len_err;
`ifdef FTDI_DEFRAMER_CSUM_EN
   logic [15:0] r_sum;
   logic        r_csum_err;
`endif

   logic w_in_payload;
   logic w_in_xfer;
   logic w_last;

   // Payload words pass straight through; the header/checksum words are always accepted.
   assign w_in_payload = (r_state == S_PAYLOAD);
   assign in_ready     = w_in_payload ? out_ready : 1'b1;
   assign w_in_xfer    = in_valid & in_ready;
   assign w_last       = (r_remaining == 16'd0);
   assign out_valid    = w_in_payload & in_valid;
   assign out_data     = w_in_payload ? in_data : 16'd0;
   assign out_last     = w_in_payload & w_last;

   assign pkt_done = r_pkt_done;
   assign len_err  = r_len_err;
   assign pkt_cnt  = r_pkt_cnt;
`ifdef FTDI_DEFRAMER_CSUM_EN
   assign csum_err = r_csum_err;
`else
   assign csum_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn_async) begin
      if (!rstn_async) begin
         r_state     <= S_HUNT;
         r_remaining <= 16'd0;
         r_pkt_cnt   <= 16'd0;
         r_pkt_done  <= 1'b0;
         r_len_err   <= 1'b0;
`ifdef FTDI_DEFRAMER_CSUM_EN
         r_sum       <= 16'd0;
         r_csum_err  <= 1'b0;
`endif
      end else begin
         r_pkt_done <= 1'b0;
         r_len_err  <= 1'b0;
`ifdef FTDI_DEFRAMER_CSUM_EN
         r_csum_err <= 1'b0;
`endif
         case (r_state)
            S_HUNT: begin
               if (w_in_xfer && (in_data == SYNC_WORD)) begin
                  r_state <= S_LEN;
               end
            end
            S_LEN: begin
               // A sync word here is a legitimate length value, never a resync.
               if (w_in_xfer) begin
                  if ({1'b0, in_data} > c_max_n) begin
                     r_len_err <= 1'b1;
                     r_state   <= S_HUNT;
                  end else begin
                     r_remaining <= in_data;
`ifdef FTDI_DEFRAMER_CSUM_EN
                     r_sum       <= 16'd0;
`endif
                     r_state     <= S_PAYLOAD;
                  end
               end
            end
            S_PAYLOAD: begin
               if (w_in_xfer) begin
                  r_remaining <= r_remaining - 16'd1;
`ifdef FTDI_DEFRAMER_CSUM_EN
                  r_sum       <= r_sum + in_data;
                  if (w_last) begin
                     r_state <= S_CSUM;
                  end
`else
                  if (w_last) begin
                     r_pkt_done <= 1'b1;
                     r_pkt_cnt  <= r_pkt_cnt + 16'd1;
                     r_state    <= S_HUNT;
                  end
`endif
               end
            end
`ifdef FTDI_DEFRAMER_CSUM_EN
            S_CSUM: begin
               if (w_in_xfer) begin
                  r_pkt_done <= 1'b1;
                  r_csum_err <= (in_data != r_sum);
                  r_pkt_cnt  <= r_pkt_cnt + 16'd1;
                  r_state    <= S_HUNT;
               end
            end
`endif
            default: r_state <= S_HUNT;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ftdi_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module  : tb_ftdi_rx_deframer
// Brief   : Scoreboard bench for ftdi_rx_deframer; checksum packets are sent
//           when FTDI_DEFRAMER_CSUM_EN is defined.
// Revision: 1.0  initial release
// ============================================================================
module tb_ftdi_rx_deframer;

   logic        clk = 1'b0;
   logic        rstn_async;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_data;
   logic        out_last;
   logic        pkt_done;
   logic        len_err;
   logic        csum_err;
   logic [15:0] pkt_cnt;

   int          checks   = 0;
   int          failures = 0;
   logic [16:0] exp_q[$];
   logic [16:0] mon_exp;
   bit          rand_ready = 1'b0;
   logic [15:0] sum;

`ifdef FTDI_DEFRAMER_CSUM_EN
   localparam logic [2:0] c_last_p = 3'b000;
`else
   localparam logic [2:0] c_last_p = 3'b001;
`endif

   ftdi_rx_deframer dut (
      .clk        (clk),
      .rstn_async (rstn_async),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .pkt_done   (pkt_done),
      .len_err    (len_err),
      .csum_err   (csum_err),
      .pkt_cnt    (pkt_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted output word must be the next queued payload word.
   always @(negedge clk) begin
      #3;
      if (rstn_async && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL out_word unexpected actual=%h last=%b required=none", out_data, out_last);
         end else begin
            mon_exp = exp_q.pop_front();
            check("out_word", {15'd0, out_last, out_data}, {15'd0, mon_exp});
         end
      end
   end

   // Present one word, wait for acceptance, then check the pulses one cycle later.
   task automatic send(input logic [15:0] w, input logic [2:0] pulses, input bit follow);
      int n;
      n        = 0;
      in_valid = 1'b1;
      in_data  = w;
      #1;
      while (!in_ready && n < 200) begin
         if (follow) check("in_ready_follow", {31'd0, in_ready}, {31'd0, out_ready});
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 200) begin
         checks++;
         failures++;
         $display("FAIL handshake_timeout actual=in_ready_low required=accept word=%h", w);
      end
      if (follow) check("in_ready_follow", {31'd0, in_ready}, {31'd0, out_ready});
      @(posedge clk);
      @(negedge clk);
      #1;
      check("pulses", {29'd0, csum_err, len_err, pkt_done}, {29'd0, pulses});
   endtask

   task automatic pay(input logic [15:0] w, input bit last, input logic [2:0] pulses, input bit follow);
      exp_q.push_back({last, w});
      send(w, pulses, follow);
   endtask

   task automatic finish_pkt(input logic [15:0] s, input logic [2:0] pulses);
`ifdef FTDI_DEFRAMER_CSUM_EN
      send(s, pulses, 1'b0);
`endif
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_data  = 16'd0;
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic do_reset;
      rstn_async = 1'b0;
      #1;
      check("async_reset", {29'd0, in_ready, out_valid, out_last}, {29'd0, 3'b100});
      in_valid = 1'b0;
      in_data  = 16'd0;
      repeat (2) @(negedge clk);
      #1;
      check("reset_state", {10'd0, in_ready, out_valid, out_last, csum_err, len_err, pkt_done, pkt_cnt},
            {10'd0, 6'b100000, 16'h0000});
      check("queue_empty_at_reset", exp_q.size(), 0);
      exp_q.delete();
      rstn_async = 1'b1;
      @(negedge clk);
      #1;
   endtask

   initial begin
      rstn_async = 1'b0;
      in_valid   = 1'b0;
      in_data    = 16'd0;
      @(negedge clk);
      #1;

      // Basic three-word packet, then a back-to-back single-word packet.
      do_reset();
      send(16'hA55A, 3'b000, 1'b0);
      send(16'h0002, 3'b000, 1'b0);
      pay(16'h0011, 1'b0, 3'b000, 1'b0);
      pay(16'h0022, 1'b0, 3'b000, 1'b0);
      pay(16'h0033, 1'b1, c_last_p, 1'b0);
      finish_pkt(16'h0066, 3'b001);
      check("pkt_cnt_t1", {16'd0, pkt_cnt}, 32'd1);
      send(16'hA55A, 3'b000, 1'b0);
      send(16'h0000, 3'b000, 1'b0);
      pay(16'h0044, 1'b1, c_last_p, 1'b0);
      finish_pkt(16'h0044, 3'b001);
      idle(3);
      check("pkt_cnt_t1b", {16'd0, pkt_cnt}, 32'd2);
      check("queue_empty_t1", exp_q.size(), 0);

      // Garbage before the sync word is dropped.
      do_reset();
      send(16'h1234, 3'b000, 1'b0);
      send(16'hA5A5, 3'b000, 1'b0);
      send(16'hA55A, 3'b000, 1'b0);
      send(16'h0000, 3'b000, 1'b0);
      pay(16'hBEEF, 1'b1, c_last_p, 1'b0);
      finish_pkt(16'hBEEF, 3'b001);
      idle(3);
      check("pkt_cnt_t2", {16'd0, pkt_cnt}, 32'd1);
      check("queue_empty_t2", exp_q.size(), 0);

      // Oversize length rejected; exactly MAX_LEN words accepted.
      do_reset();
      send(16'hA55A, 3'b000, 1'b0);
      send(16'h0400, 3'b010, 1'b0);
      send(16'h0001, 3'b000, 1'b0);
      idle(3);
      check("pkt_cnt_t3", {16'd0, pkt_cnt}, 32'd0);
      send(16'hA55A, 3'b000, 1'b0);
      send(16'h03FF, 3'b000, 1'b0);
      sum = 16'd0;
      for (int i = 0; i < 1024; i++) begin
         sum = sum + 16'(i);
         pay(16'(i), (i == 1023), (i == 1023) ? c_last_p : 3'b000, 1'b0);
      end
      finish_pkt(sum, 3'b001);
      idle(3);
      check("pkt_cnt_t3b", {16'd0, pkt_cnt}, 32'd1);
      check("queue_empty_t3", exp_q.size(), 0);

      // Random backpressure over a 64-word packet.
      do_reset();
      rand_ready = 1'b1;
      send(16'hA55A, 3'b000, 1'b0);
      send(16'h003F, 3'b000, 1'b0);
      sum = 16'd0;
      for (int i = 0; i < 64; i++) begin
         sum = sum + (16'h4000 + 16'(i));
         pay(16'h4000 + 16'(i), (i == 63), (i == 63) ? c_last_p : 3'b000, 1'b1);
      end
      finish_pkt(sum, 3'b001);
      rand_ready = 1'b0;
      idle(4);
      check("pkt_cnt_t4", {16'd0, pkt_cnt}, 32'd1);
      check("queue_empty_t4", exp_q.size(), 0);

`ifdef FTDI_DEFRAMER_CSUM_EN
      // Checksum match then mismatch.
      do_reset();
      send(16'hA55A, 3'b000, 1'b0);
      send(16'h0001, 3'b000, 1'b0);
      pay(16'h0100, 1'b0, 3'b000, 1'b0);
      pay(16'h0200, 1'b1, 3'b000, 1'b0);
      send(16'h0300, 3'b001, 1'b0);
      send(16'hA55A, 3'b000, 1'b0);
      send(16'h0001, 3'b000, 1'b0);
      pay(16'h0100, 1'b0, 3'b000, 1'b0);
      pay(16'h0200, 1'b1, 3'b000, 1'b0);
      send(16'h0301, 3'b101, 1'b0);
      idle(3);
      check("pkt_cnt_t5", {16'd0, pkt_cnt}, 32'd2);
      check("queue_empty_t5", exp_q.size(), 0);
`endif

      // Reset mid-packet abandons it cleanly.
      do_reset();
      send(16'hA55A, 3'b000, 1'b0);
      send(16'h0004, 3'b000, 1'b0);
      pay(16'h0001, 1'b0, 3'b000, 1'b0);
      pay(16'h0002, 1'b0, 3'b000, 1'b0);
      do_reset();
      send(16'hA55A, 3'b000, 1'b0);
      send(16'h0000, 3'b000, 1'b0);
      pay(16'h0007, 1'b1, c_last_p, 1'b0);
      finish_pkt(16'h0007, 3'b001);
      idle(3);
      check("pkt_cnt_t6", {16'd0, pkt_cnt}, 32'd1);
      check("queue_empty_t6", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
